// File: rtl/dac_dual_out_if.sv
// Dual-channel DAC stage bus: DSP-side samples and strobes, DAC-side codes and status.
interface dac_dual_out_if #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned IN_WIDTH   = 16
);
  logic                  dac_locked_i;
  logic                  dac_dat_a_en_i;
  logic                  dac_dat_b_en_i;
  logic                  dac_dat_a_rst_i;
  logic                  dac_dat_b_rst_i;
  logic [IN_WIDTH-1:0]   dac_dat_a_i;
  logic [IN_WIDTH-1:0]   dac_dat_b_i;
  logic [DATA_WIDTH-1:0] dac_dat_a_o;
  logic [DATA_WIDTH-1:0] dac_dat_b_o;
  logic                  dac_rst_o;
  logic                  dac_ready_o;
  logic                  dac_sat_a_o;
  logic                  dac_sat_b_o;

  modport master (
    output dac_locked_i, dac_dat_a_en_i, dac_dat_b_en_i, dac_dat_a_rst_i, dac_dat_b_rst_i,
           dac_dat_a_i, dac_dat_b_i,
    input  dac_dat_a_o, dac_dat_b_o, dac_rst_o, dac_ready_o, dac_sat_a_o, dac_sat_b_o
  );

  modport slave (
    input  dac_locked_i, dac_dat_a_en_i, dac_dat_b_en_i, dac_dat_a_rst_i, dac_dat_b_rst_i,
           dac_dat_a_i, dac_dat_b_i,
    output dac_dat_a_o, dac_dat_b_o, dac_rst_o, dac_ready_o, dac_sat_a_o, dac_sat_b_o
  );
endinterface

// File: rtl/dac_dual_out.sv
// Dual-channel DAC output stage: lock sequencing, saturation, sticky flags, idle timeout, swap.
// Define DAC_OFFSET_BIN_EN for offset-binary output codes (two's complement otherwise).
module dac_dual_out #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned LOCK_DLY   = 16,
  parameter int unsigned TIMEOUT    = 0,
  parameter int unsigned CH_SWAP    = 1
) (
  input  logic           dac_clk_i,
  input  logic           dac_rstn_i,
  dac_dual_out_if.slave  bus
);

  localparam int unsigned LCW = $clog2(LOCK_DLY + 1);
  localparam int unsigned TW  = IN_WIDTH - DATA_WIDTH + 1;

`ifdef DAC_OFFSET_BIN_EN
  localparam logic [DATA_WIDTH-1:0] ZERO_CODE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
  localparam logic [DATA_WIDTH-1:0] ZERO_CODE = '0;
`endif

  function automatic logic [DATA_WIDTH-1:0] enc(input logic [DATA_WIDTH-1:0] v);
`ifdef DAC_OFFSET_BIN_EN
    return {~v[DATA_WIDTH-1], v[DATA_WIDTH-2:0]};
`else
    return v;
`endif
  endfunction

  typedef enum logic [1:0] {ST_RESET, ST_WAIT, ST_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [LCW-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic            r_dac_rst, r_dac_ready;
  logic            w_run_nxt;

  // Lock sequencer state register; status outputs follow the next state so they align with it
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      r_state     <= ST_RESET;
      r_lock_cnt  <= '0;
      r_dac_rst   <= 1'b1;
      r_dac_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_dac_rst   <= !w_run_nxt;
      r_dac_ready <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_RESET: begin
        if (bus.dac_locked_i) begin
          w_state_nxt    = ST_WAIT;
          w_lock_cnt_nxt = LCW'(1);
        end
      end
      ST_WAIT: begin
        if (!bus.dac_locked_i) begin
          w_state_nxt    = ST_RESET;
          w_lock_cnt_nxt = '0;
        end else if (r_lock_cnt == LCW'(LOCK_DLY)) begin
          w_state_nxt    = ST_RUN;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
        end
      end
      ST_RUN: begin
        if (!bus.dac_locked_i) begin
          w_state_nxt    = ST_RESET;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_RESET;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  assign w_run_nxt = (w_state_nxt == ST_RUN);

  logic [1:0]                 w_en, w_clr, w_sat;
  logic [1:0][IN_WIDTH-1:0]   w_din;
  logic [1:0][DATA_WIDTH-1:0] w_hold;

  assign w_en  = {bus.dac_dat_b_en_i,  bus.dac_dat_a_en_i};
  assign w_clr = {bus.dac_dat_b_rst_i, bus.dac_dat_a_rst_i};
  assign w_din = {bus.dac_dat_b_i,     bus.dac_dat_a_i};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [TW-1:0]         w_top;
    logic                  w_ovf;
    logic                  w_tmo;
    logic [DATA_WIDTH-1:0] w_clamped;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_sat;

    // In range only when every bit above the DAC sign bit replicates it
    assign w_top     = w_din[ch][IN_WIDTH-1:DATA_WIDTH-1];
    assign w_ovf     = !((&w_top) || !(|w_top));
    assign w_clamped = !w_ovf      ? w_din[ch][DATA_WIDTH-1:0] :
                       w_top[TW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                     {1'b0, {(DATA_WIDTH-1){1'b1}}};

    if (TIMEOUT > 0) begin : g_tmo
      localparam int unsigned TCW = $clog2(TIMEOUT + 1);
      logic [TCW-1:0] r_tmo_cnt;

      always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i)                       r_tmo_cnt <= '0;
        else if (w_en[ch] || w_clr[ch])        r_tmo_cnt <= '0;
        else if (r_tmo_cnt != TCW'(TIMEOUT))   r_tmo_cnt <= r_tmo_cnt + TCW'(1);
      end

      // Counter parks at TIMEOUT, so the zero keeps being reasserted until the next strobe
      assign w_tmo = (r_tmo_cnt >= TCW'(TIMEOUT - 1));
    end else begin : g_no_tmo
      assign w_tmo = 1'b0;
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
        r_hold <= '0;
        r_sat  <= 1'b0;
      end else if (w_clr[ch]) begin
        r_hold <= '0;
        r_sat  <= 1'b0;
      end else if (w_en[ch]) begin
        r_hold <= w_clamped;
        if (w_ovf) r_sat <= 1'b1;
      end else if (w_tmo) begin
        r_hold <= '0;
      end
    end

    assign w_hold[ch] = r_hold;
    assign w_sat[ch]  = r_sat;
  end

  logic [DATA_WIDTH-1:0] w_sel_a, w_sel_b;
  logic [DATA_WIDTH-1:0] r_dat_a, r_dat_b;

  assign w_sel_a = (CH_SWAP != 0) ? w_hold[1] : w_hold[0];
  assign w_sel_b = (CH_SWAP != 0) ? w_hold[0] : w_hold[1];

  // Pins carry the zero code whenever the sequencer is (or is about to be) out of RUN
  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      r_dat_a <= ZERO_CODE;
      r_dat_b <= ZERO_CODE;
    end else begin
      r_dat_a <= w_run_nxt ? enc(w_sel_a) : ZERO_CODE;
      r_dat_b <= w_run_nxt ? enc(w_sel_b) : ZERO_CODE;
    end
  end

  assign bus.dac_dat_a_o = r_dat_a;
  assign bus.dac_dat_b_o = r_dat_b;
  assign bus.dac_rst_o   = r_dac_rst;
  assign bus.dac_ready_o = r_dac_ready;
  assign bus.dac_sat_a_o = w_sat[0];
  assign bus.dac_sat_b_o = w_sat[1];

endmodule

// File: tb/tb_dac_dual_out.sv
// Bench for dac_dual_out: directed literal checks plus randomized traffic against a behavioural model.
module tb_dac_dual_out;

  localparam int DW       = 14;
  localparam int IW       = 16;
  localparam int LOCK_DLY = 16;
  localparam int TIMEOUT  = 8;
  localparam int CH_SWAP  = 1;
  localparam int MAXV     = (1 << (DW - 1)) - 1;
  localparam int MINV     = -(1 << (DW - 1));

`ifdef DAC_OFFSET_BIN_EN
  localparam logic [DW-1:0] ZERO = 14'h2000;
  localparam logic [DW-1:0] NEG1 = 14'h1FFF;
`else
  localparam logic [DW-1:0] ZERO = 14'h0000;
  localparam logic [DW-1:0] NEG1 = 14'h3FFF;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  dac_dual_out_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) bus ();

  dac_dual_out #(
    .DATA_WIDTH(DW), .IN_WIDTH(IW), .LOCK_DLY(LOCK_DLY), .TIMEOUT(TIMEOUT), .CH_SWAP(CH_SWAP)
  ) dut (
    .dac_clk_i  (clk),
    .dac_rstn_i (rstn),
    .bus        (bus.slave)
  );

  function automatic logic [DW-1:0] enc(input int h);
    logic [DW-1:0] c;
    c = DW'(h);
`ifdef DAC_OFFSET_BIN_EN
    c[DW-1] = ~c[DW-1];
`endif
    return c;
  endfunction

  function automatic int clamp(input logic [IW-1:0] x);
    int v;
    v = int'($signed(x));
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: RUN means lock has been seen on LOCK_DLY+1 consecutive edges
  int            m_streak = 0;
  int            m_hold[2] = '{0, 0};
  bit            m_sat[2]  = '{1'b0, 1'b0};
  int            m_age[2]  = '{0, 0};
  logic [DW-1:0] m_out_a   = ZERO;
  logic [DW-1:0] m_out_b   = ZERO;
  bit            m_rst     = 1'b1;
  bit            m_ready   = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_streak = 0;
      m_hold   = '{0, 0};
      m_sat    = '{1'b0, 1'b0};
      m_age    = '{0, 0};
      m_out_a  = ZERO;
      m_out_b  = ZERO;
      m_rst    = 1'b1;
      m_ready  = 1'b0;
    end else begin
      int  old_hold[2];
      bit  run;
      bit  en[2], cl[2];
      logic [IW-1:0] d[2];
      old_hold = m_hold;
      en = '{bus.dac_dat_a_en_i, bus.dac_dat_b_en_i};
      cl = '{bus.dac_dat_a_rst_i, bus.dac_dat_b_rst_i};
      d  = '{bus.dac_dat_a_i, bus.dac_dat_b_i};
      m_streak = bus.dac_locked_i ? ((m_streak > LOCK_DLY) ? LOCK_DLY + 1 : m_streak + 1) : 0;
      run = (m_streak > LOCK_DLY);
      for (int c = 0; c < 2; c++) begin
        if (cl[c]) begin
          m_hold[c] = 0; m_sat[c] = 1'b0; m_age[c] = 0;
        end else if (en[c]) begin
          m_hold[c] = clamp(d[c]);
          if (m_hold[c] != int'($signed(d[c]))) m_sat[c] = 1'b1;
          m_age[c] = 0;
        end else begin
          if (m_age[c] < 1000) m_age[c]++;
          if (m_age[c] >= TIMEOUT) m_hold[c] = 0;
        end
      end
      m_out_a = run ? enc(CH_SWAP ? old_hold[1] : old_hold[0]) : ZERO;
      m_out_b = run ? enc(CH_SWAP ? old_hold[0] : old_hold[1]) : ZERO;
      m_rst   = !run;
      m_ready = run;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dat_a_o", int'(bus.dac_dat_a_o), int'(m_out_a));
      chk("dat_b_o", int'(bus.dac_dat_b_o), int'(m_out_b));
      chk("rst_o",   int'(bus.dac_rst_o),   int'(m_rst));
      chk("ready_o", int'(bus.dac_ready_o), int'(m_ready));
      chk("sat_a_o", int'(bus.dac_sat_a_o), int'(m_sat[0]));
      chk("sat_b_o", int'(bus.dac_sat_b_o), int'(m_sat[1]));
    end
  end

  task automatic strobe(input logic ea, input logic [IW-1:0] da, input logic ra,
                        input logic eb, input logic [IW-1:0] db, input logic rb);
    @(negedge clk);
    bus.dac_dat_a_en_i = ea; bus.dac_dat_a_i = da; bus.dac_dat_a_rst_i = ra;
    bus.dac_dat_b_en_i = eb; bus.dac_dat_b_i = db; bus.dac_dat_b_rst_i = rb;
    @(negedge clk);
    bus.dac_dat_a_en_i = 1'b0; bus.dac_dat_a_rst_i = 1'b0;
    bus.dac_dat_b_en_i = 1'b0; bus.dac_dat_b_rst_i = 1'b0;
  endtask

  // Called right after lock is driven high; RUN must appear on the (LOCK_DLY+1)th edge
  task automatic measure_lock(input string nm);
    int cnt;
    cnt = 0;
    while (cnt < 3 * LOCK_DLY) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.dac_ready_o) break;
    end
    chk(nm, cnt, LOCK_DLY + 1);
    chk({nm, "_rst"}, int'(bus.dac_rst_o), 0);
  endtask

  task automatic next_out();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [IW-1:0] specials[6];
    int rate;
    specials = '{16'h7FFF, 16'h8000, 16'h1FFF, 16'hE000, 16'h2000, 16'hDFFF};
    bus.dac_locked_i = 1'b0;
    bus.dac_dat_a_en_i = 1'b0; bus.dac_dat_b_en_i = 1'b0;
    bus.dac_dat_a_rst_i = 1'b0; bus.dac_dat_b_rst_i = 1'b0;
    bus.dac_dat_a_i = '0; bus.dac_dat_b_i = '0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dat_a", int'(bus.dac_dat_a_o), int'(ZERO));
    chk("reset_rst",   int'(bus.dac_rst_o), 1);
    chk("reset_ready", int'(bus.dac_ready_o), 0);

    // Lock sequencing, then a one-cycle lock drop
    @(negedge clk);
    rstn = 1'b1;
    bus.dac_locked_i = 1'b1;
    measure_lock("lock_delay");
    @(negedge clk);
    bus.dac_locked_i = 1'b0;
    next_out();
    chk("lockloss_rst", int'(bus.dac_rst_o), 1);
    @(negedge clk);
    bus.dac_locked_i = 1'b1;
    measure_lock("relock_delay");

    // Saturation and sticky flag on channel A (lands on pin B through the swap)
    strobe(1'b1, 16'h7FFF, 1'b0, 1'b0, '0, 1'b0);
    chk("sat_set", int'(bus.dac_sat_a_o), 1);
    next_out();
    chk("sat_pos", int'(bus.dac_dat_b_o), int'(enc(14'h1FFF)));
    strobe(1'b1, 16'h8000, 1'b0, 1'b0, '0, 1'b0);
    next_out();
    chk("sat_neg", int'(bus.dac_dat_b_o), int'(enc(14'h2000)));
    strobe(1'b1, 16'h0100, 1'b0, 1'b0, '0, 1'b0);
    chk("sat_sticky", int'(bus.dac_sat_a_o), 1);
    next_out();
    chk("pass_0100", int'(bus.dac_dat_b_o), int'(enc(14'h0100)));
    strobe(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("sat_clear", int'(bus.dac_sat_a_o), 0);

    // Channel clear beats a simultaneous enable
    strobe(1'b1, 16'h7FFF, 1'b0, 1'b0, '0, 1'b0);
    strobe(1'b1, 16'h0123, 1'b1, 1'b0, '0, 1'b0);
    chk("prio_sat", int'(bus.dac_sat_a_o), 0);
    next_out();
    chk("prio_hold", int'(bus.dac_dat_b_o), int'(ZERO));

    // Idle timeout: eight cycles of data, then zero; a new strobe restores it
    strobe(1'b1, 16'h0400, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      next_out();
      chk($sformatf("tmo_cyc%0d", i), int'(bus.dac_dat_b_o),
          (i <= TIMEOUT) ? int'(enc(14'h0400)) : int'(ZERO));
    end
    strobe(1'b1, 16'h0400, 1'b0, 1'b0, '0, 1'b0);
    next_out();
    chk("tmo_restore", int'(bus.dac_dat_b_o), int'(enc(14'h0400)));

    // Swap and encoding
    strobe(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0);
    next_out();
    chk("swap_a", int'(bus.dac_dat_a_o), int'(enc(14'h0002)));
    chk("swap_b", int'(bus.dac_dat_b_o), int'(enc(14'h0001)));
    strobe(1'b1, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    next_out();
    chk("code_neg1", int'(bus.dac_dat_a_o), int'(NEG1));
    chk("code_zero", int'(bus.dac_dat_b_o), int'(ZERO));

    // Randomized traffic with varying strobe density and occasional lock loss
    rate = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 200 == 0) rate = (cyc / 200 % 3 == 0) ? 5 : ((cyc / 200 % 3 == 1) ? 30 : 90);
      bus.dac_locked_i    = ($urandom_range(0, 299) != 0);
      bus.dac_dat_a_en_i  = ($urandom_range(0, 99) < rate);
      bus.dac_dat_b_en_i  = ($urandom_range(0, 99) < rate);
      bus.dac_dat_a_rst_i = ($urandom_range(0, 99) < 2);
      bus.dac_dat_b_rst_i = ($urandom_range(0, 99) < 2);
      bus.dac_dat_a_i = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : IW'($urandom);
      bus.dac_dat_b_i = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : IW'($urandom);
    end
    @(negedge clk);
    bus.dac_locked_i = 1'b1;
    bus.dac_dat_a_en_i = 1'b0; bus.dac_dat_b_en_i = 1'b0;
    bus.dac_dat_a_rst_i = 1'b0; bus.dac_dat_b_rst_i = 1'b0;
    repeat (LOCK_DLY + 4) @(negedge clk);

    // Asynchronous reset in the middle of streaming
    strobe(1'b1, 16'h7FFF, 1'b0, 1'b1, 16'h0555, 1'b0);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_dat_a", int'(bus.dac_dat_a_o), int'(ZERO));
    chk("arst_dat_b", int'(bus.dac_dat_b_o), int'(ZERO));
    chk("arst_rst",   int'(bus.dac_rst_o), 1);
    chk("arst_sat_a", int'(bus.dac_sat_a_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dac_dual_out.md
# dac_dual_out

Dual-channel, parametrised DAC output stage between the DSP datapath and the fast DAC pins, running entirely in the DAC clock domain. Each channel latches input samples on an enable strobe and saturates them from the wider DSP width to the DAC width. A lock-sequencing state machine holds the DAC in reset until the clock source is stable. Per-channel sticky saturation flags, an optional inactivity timeout that returns a channel to zero, and a compile-time channel swap complete the block.

## Interface
- `DATA_WIDTH`, 14: DAC code width.
- `IN_WIDTH`, 16: signed input sample width; must be ≥ `DATA_WIDTH`.
- `LOCK_DLY`, 16: cycles `dac_locked_i` must stay high before leaving reset; ≥1.
- `TIMEOUT`, 0: cycles without an enable before a channel is forced to zero; 0 disables the timeout.
- `CH_SWAP`, 1: when 1, channel A data drives `dac_dat_b_o` and channel B data drives `dac_dat_a_o`.
- `dac_clk_i` in 1: the single clock.
- `dac_rstn_i` in 1: asynchronous, active-low reset.
- `dac_locked_i` in 1: clock-source lock, already synchronous to `dac_clk_i`.
- `dac_dat_a_en_i` / `dac_dat_b_en_i` in 1: sample strobe per channel.
- `dac_dat_a_rst_i` / `dac_dat_b_rst_i` in 1: synchronous per-channel clear.
- `dac_dat_a_i` / `dac_dat_b_i` in `IN_WIDTH`: signed two's-complement samples.
- `dac_dat_a_o` / `dac_dat_b_o` out `DATA_WIDTH`: registered DAC codes.
- `dac_rst_o` out 1: DAC reset, active high.
- `dac_ready_o` out 1: high only in state RUN.
- `dac_sat_a_o` / `dac_sat_b_o` out 1: sticky saturation flags.

## Operation
- Lock FSM has three states: RESET, WAIT and RUN. `dac_rstn_i` low puts it in RESET.
- RESET: moves to WAIT when `dac_locked_i`=1. The lock counter loads 1 on that transition.
- WAIT: counts cycles with `dac_locked_i`=1 and moves to RUN when the count reaches `LOCK_DLY`.
- RESET/WAIT outputs: `dac_rst_o`=1 and `dac_ready_o`=0.
- RUN outputs: `dac_rst_o`=0 and `dac_ready_o`=1.
- Lock loss: `dac_locked_i`=0 in WAIT or RUN sends the FSM to RESET on the next edge and clears the counter.
- Per-channel hold register, updated in priority order:
  - 1. Channel `rst_i`: hold ← 0 and sat flag ← 0. This wins over a simultaneous enable.
  - 2. Channel `en_i`: hold ← sat(in). If clamping occurred, sat flag ← 1.
  - 3. Timeout reached: hold ← 0.
  - 4. Otherwise: hold keeps its value.
- Saturation: the input is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. When `IN_WIDTH`=`DATA_WIDTH`, the value passes through and the flag never sets.
- Timeout counter (`TIMEOUT`>0): one per channel.
  - Clears on `en_i` or `rst_i`.
  - Otherwise increments and saturates at `TIMEOUT`.
  - Forces the hold register to 0 on the cycle the count equals `TIMEOUT`−1 with no enable.
  - The counter stays saturated until the next enable, so the zero persists.
- Output register:
  - In RUN: loads the (optionally swapped) hold values, encoded per Configuration.
  - Outside RUN: loads the zero code.
- Hold registers and sat flags keep updating in all FSM states.
- Reset values: outputs = zero code, `dac_rst_o`=1, `dac_ready_o`=0, sat flags 0, hold registers 0, counters 0.

## Timing
- Data latency: an enable sampled at edge n updates the hold register at edge n; the value appears on the output at edge n+1. That is two registers, 1 cycle from strobe to pins.
- The sat flag is set at the same edge as the hold update.
- Lock: `dac_locked_i` rising before edge k (in RESET) gives `dac_rst_o` falling after edge k+`LOCK_DLY`.
- Lock loss: `dac_rst_o`=1 one edge after `dac_locked_i` falls; outputs carry the zero code from that same edge.
- Timeout: with the last enable at edge n, the hold register is 0 at edge n+`TIMEOUT` and the output is 0 at n+`TIMEOUT`+1.
- Asynchronous reset takes effect immediately. Release is synchronous to the next `dac_clk_i` edge; the source must deassert it cleanly.

## Configuration
- `DAC_OFFSET_BIN_EN` defined: the output code is offset binary (MSB inverted). The zero code is 2^(DATA_WIDTH−1), i.e. 0x2000 for 14 bits.
- `DAC_OFFSET_BIN_EN` undefined: the output code is two's complement and the zero code is 0.

## Test plan
- Lock: reset released, `dac_locked_i`=1 with `LOCK_DLY`=16 → `dac_rst_o` falls and `dac_ready_o` rises exactly 16 edges later. Drop lock for 1 cycle → back to RESET and a full 16-cycle wait.
- Saturation: DW=14/IW=16 with input 0x7FFF → output 0x1FFF and `dac_sat_a_o`=1. Input 0x8000 → 0x2000 (two's). Input 0x0100 → 0x0100; the flag stays set until `dac_dat_a_rst_i`.
- Priority: `en`=1 and `rst`=1 on the same cycle with input 0x0123 → hold 0 and flag cleared.
- Timeout: `TIMEOUT`=8, strobe once with 0x0400 and no further enables → output 0x0400 for 8 cycles, then 0. A new enable restores the sampled value.
- Swap and encoding: `CH_SWAP`=1, A=0x0001, B=0x0002 → `dac_dat_a_o`=0x0002, `dac_dat_b_o`=0x0001. With `DAC_OFFSET_BIN_EN`, input 0 → 0x2000 and input −1 → 0x1FFF.
- Reset mid-stream: assert `dac_rstn_i` while streaming → outputs go to the zero code, `dac_rst_o`=1 and flags clear immediately, without waiting for a clock edge.
